uart_tx: RTL and testbench

- Transmit half of the UART link. Serialises one 8-bit byte per request into an 11-bit frame on a single line: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
- The frame is bit-compatible with the team's RECEIVER block. That block sees start, then a 10-bit {stop, parity, data[7:0]} word.
- Sits between the host-side byte source and the serial pin. One clock domain; bit timing comes from an internal clock divider.

---
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Transmit half of the UART link. Serialises one byte per
//                accepted request into an 11-bit frame on a single line:
//                start (0), data[0..7] LSB first, parity, stop (1).
//                Bit timing comes from an internal divide-by-CLKS_PER_BIT
//                baud counter. All outputs are registered.
//
//  Parameters  : CLKS_PER_BIT - clock cycles per serial bit (1..65535)
//
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous, active-high reset
//                tx_start   - request to send tx_data_in (accepted in IDLE)
//                tx_data_in - byte to send, captured on acceptance
//                tx_out     - serial line, idle high
//                tx_busy    - high from the acceptance edge until the frame ends
//                tx_done    - one-cycle pulse when a frame completes
//
//  Build option: UART_TX_ODD_PARITY_EN - when defined the parity bit is odd
//                (~^data); otherwise it is even (^data). Frame timing is the
//                same in both builds.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Counter width is at least one bit so CLKS_PER_BIT=1 still builds.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // State encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             r_parity;
    logic             r_tx_out;
    logic             r_busy;
    logic             r_done;

    logic             w_bit_end;
    logic             w_parity;

    // Last clock of the current bit time: the state advances on this edge.
    assign w_bit_end = (r_cnt == c_last_cnt);

    // Parity is computed from the incoming byte at acceptance so the PARITY
    // state only has to replay a stored bit.
`ifdef UART_TX_ODD_PARITY_EN
    assign w_parity = ~^tx_data_in;
`else
    assign w_parity = ^tx_data_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'd0;
            r_parity  <= 1'b0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // tx_done is a single-cycle pulse; only the STOP exit sets it.
            r_done <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                    if (tx_start) begin
                        // Start bit and busy are driven from the acceptance
                        // edge itself, so there is no extra latency cycle.
                        r_shreg   <= tx_data_in;
                        r_parity  <= w_parity;
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx_out  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_st_start;
                    end
                end

                c_st_start: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx_out  <= r_shreg[0];
                        r_state   <= c_st_data;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                c_st_data: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shreg <= {1'b0, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_tx_out <= r_parity;
                            r_state  <= c_st_parity;
                        end else begin
                            // Next bit is the one about to shift into [0].
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx_out  <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                c_st_parity: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_out <= 1'b1;
                        r_state  <= c_st_stop;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                c_st_stop: begin
                    if (w_bit_end) begin
                        // Back in IDLE for the tx_done cycle; a request held
                        // during that cycle is accepted on the following edge.
                        r_cnt    <= '0;
                        r_tx_out <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle line.
                    r_cnt    <= '0;
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx at CLKS_PER_BIT=4.
//                Frames are held as 11-bit vectors, bit k being the k-th bit
//                on the line: {stop, parity, data[7:0], start}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME_CYC    = 11 * CLKS_PER_BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_ODD_PARITY_EN
    localparam logic [10:0] c_frame_a5 = 11'b11101001010;
    localparam logic [10:0] c_frame_07 = 11'b10000001110;
    localparam logic [10:0] c_frame_ff = 11'b11111111110;
    localparam logic [10:0] c_frame_3c = 11'b11001111000;
    localparam logic [10:0] c_frame_81 = 11'b11100000010;
    localparam logic        c_par_sum  = 1'b1;
`else
    localparam logic [10:0] c_frame_a5 = 11'b10101001010;
    localparam logic [10:0] c_frame_07 = 11'b11000001110;
    localparam logic [10:0] c_frame_ff = 11'b10111111110;
    localparam logic [10:0] c_frame_3c = 11'b10001111000;
    localparam logic [10:0] c_frame_81 = 11'b10100000010;
    localparam logic        c_par_sum  = 1'b0;
`endif

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: one-cycle request; returns at the negedge after the
    // acceptance edge (cycle 0 of the frame).
    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        tx_start   = 1'b1;
        tx_data_in = d;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        tx_start   = 1'b0;
        tx_data_in = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%b busy=%b done=%b required out=1 busy=0 done=0",
                     tx_out, tx_busy, tx_done);
        end
        @(negedge clk);
        rst = 1'b0;

        // Abort during data bit 3 (cycles 16..19); 0xF0 has bit 3 = 0.
        accept(8'hF0);
        repeat (17) @(negedge clk);
        checks++;
        if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_abort: out=%b busy=%b required out=0 busy=1",
                     tx_out, tx_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_abort: out=%b busy=%b done=%b required out=1 busy=0 done=0",
                     tx_out, tx_busy, tx_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_stays_idle cycle %0d: out=%b busy=%b done=%b required 1/0/0",
                         c, tx_out, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_single_frame();
        accept(8'hA5);
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (tx_out !== c_frame_a5[c / CLKS_PER_BIT] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL single_frame cycle %0d: out=%b busy=%b done=%b required out=%b busy=1 done=0",
                         c, tx_out, tx_busy, tx_done, c_frame_a5[c / CLKS_PER_BIT]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL single_done: out=%b busy=%b done=%b required out=1 busy=0 done=1",
                     tx_out, tx_busy, tx_done);
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse_width: busy=%b done=%b required busy=0 done=0",
                     tx_busy, tx_done);
        end
    endtask

    task automatic test_parity();
        accept(8'h07);
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (tx_out !== c_frame_07[c / CLKS_PER_BIT]) begin
                errors++;
                $display("FAIL parity_07 cycle %0d: out=%b required %b",
                         c, tx_out, c_frame_07[c / CLKS_PER_BIT]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1) begin
            errors++;
            $display("FAIL parity_07_done: done=%b required 1", tx_done);
        end
    endtask

    task automatic test_back_to_back();
        accept(8'hFF);
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (tx_out !== c_frame_ff[c / CLKS_PER_BIT] || tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first cycle %0d: out=%b busy=%b required out=%b busy=1",
                         c, tx_out, tx_busy, c_frame_ff[c / CLKS_PER_BIT]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b required 1", tx_done);
        end
        // Request during the tx_done cycle.
        tx_start   = 1'b1;
        tx_data_in = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        tx_start   = 1'b0;
        tx_data_in = 8'hFF;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (tx_out !== c_frame_3c[c / CLKS_PER_BIT] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second cycle %0d: out=%b busy=%b done=%b required out=%b busy=1 done=0",
                         c, tx_out, tx_busy, tx_done, c_frame_3c[c / CLKS_PER_BIT]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_done: busy=%b done=%b required busy=0 done=1",
                     tx_busy, tx_done);
        end
    endtask

    task automatic test_busy_ignore();
        int dones;
        dones = 0;
        accept(8'h81);
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            // Parity bit occupies cycles 36..39.
            tx_start   = (c == 37);
            tx_data_in = (c == 37) ? 8'h00 : 8'h81;
            checks++;
            if (tx_out !== c_frame_81[c / CLKS_PER_BIT] || tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_ignore_frame cycle %0d: out=%b busy=%b required out=%b busy=1",
                         c, tx_out, tx_busy, c_frame_81[c / CLKS_PER_BIT]);
            end
        end
        tx_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_done === 1'b1) dones++;
            checks++;
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_ignore_no_second cycle %0d: out=%b busy=%b required out=1 busy=0",
                         c, tx_out, tx_busy);
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_ignore_done_count: %0d pulses required 1", dones);
        end
    endtask

    // Line-side receiver: finds the start edge, samples mid-bit, and checks
    // the {stop, parity, data} word.
    task automatic test_loopback();
        logic [7:0] bytes [4];
        logic [7:0] rx_data;
        logic       rx_par;
        logic       rx_stop;
        logic       parity_error;
        logic       stop_error;
        int         w;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        bytes[3] = 8'hAA;
        for (int b = 0; b < 4; b++) begin
            accept(bytes[b]);
            w = 0;
            while (tx_out !== 1'b0 && w < 20) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 20) begin
                errors++;
                $display("FAIL loopback_start byte %0d: no start bit seen", b);
            end
            repeat (CLKS_PER_BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLKS_PER_BIT) @(negedge clk);
                rx_data[i] = tx_out;
            end
            repeat (CLKS_PER_BIT) @(negedge clk);
            rx_par = tx_out;
            repeat (CLKS_PER_BIT) @(negedge clk);
            rx_stop      = tx_out;
            parity_error = ((^rx_data) ^ rx_par) !== c_par_sum;
            stop_error   = (rx_stop !== 1'b1);
            checks++;
            if (rx_data !== bytes[b] || parity_error !== 1'b0 || stop_error !== 1'b0) begin
                errors++;
                $display("FAIL loopback byte %0d: rx=%h perr=%b serr=%b required rx=%h perr=0 serr=0",
                         b, rx_data, parity_error, stop_error, bytes[b]);
            end
            w = 0;
            while (tx_done !== 1'b1 && w < 2 * CLKS_PER_BIT) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 2 * CLKS_PER_BIT) begin
                errors++;
                $display("FAIL loopback_done byte %0d: tx_done not seen", b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
